sonar_ram_arbiter: RTL
======================

Name: sonar_ram_arbiter

Overview:
- Sequencer and arbiter for the 4096x8 simple-dual-port echo buffer RAM (write port A, read port B, 1-cycle read latency).
- Port A is shared between the sonar sample writer and an internal bulk-clear engine.
- Port B is shared between the video line fetcher and the host/UART readback path.
- Sits between the echo capture logic, the display path and the RAM wrapper, and drives all RAM control pins.

Parameters:
- ADDR_W, 12: RAM address width; clear sweeps 0 .. 2^ADDR_W-1.
- DATA_W, 8: RAM data width.
- CLEAR_VAL, 8'h00: value written by the clear engine.

Ports:
- clk  in  1  single system clock; also drives RAM clka/clkb.
- reset  in  1  asynchronous, active-high reset.
- s_wr_req  in  1  sample writer request.
- s_wr_addr  in  ADDR_W  sample write address.
- s_wr_data  in  DATA_W  sample write data.
- s_wr_ack  out  1  sample write accepted this cycle.
- clr_start  in  1  pulse: start full-buffer clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse after last clear write.
- v_rd_req  in  1  video read request.
- v_rd_addr  in  ADDR_W  video read address.
- v_rd_gnt  out  1  video request granted this cycle.
- v_rd_valid  out  1  video read data valid.
- h_rd_req  in  1  host read request.
- h_rd_addr  in  ADDR_W  host read address.
- h_rd_gnt  out  1  host request granted this cycle.
- h_rd_valid  out  1  host read data valid.
- rd_data  out  DATA_W  shared read data (qualified by the *_rd_valid outputs).
- ram_cea  out  1  RAM port A clock enable (write strobe).
- ram_ada  out  ADDR_W  RAM write address.
- ram_din  out  DATA_W  RAM write data.
- ram_ceb  out  1  RAM port B clock enable.
- ram_adb  out  ADDR_W  RAM read address.
- ram_oce  out  1  RAM output clock enable; tied 1.
- ram_reseta  out  1  RAM port A reset; equals reset.
- ram_resetb  out  1  RAM port B reset; equals reset.
- ram_dout  in  DATA_W  RAM read data.

Behaviour:
- Reset values:
  - clr_busy, clr_done, v_rd_valid, h_rd_valid = 0.
  - Clear FSM = IDLE; clear counter = 0.
  - Starvation counter (if present) = 0.
  - ram_oce = 1 at all times.
- Write port A:
  - Sample writer has absolute priority. s_wr_ack = s_wr_req, combinational, same cycle.
  - While s_wr_req=1: ram_cea=1, ram_ada=s_wr_addr, ram_din=s_wr_data.
  - Otherwise, if the FSM is in CLEAR: ram_cea=1, ram_ada=clear counter, ram_din=CLEAR_VAL.
  - Otherwise ram_cea=0.
- Clear FSM (states IDLE, CLEAR, DONE):
  - IDLE -> CLEAR on clr_start=1; counter := 0.
  - In CLEAR, the counter increments only on cycles where the clear write is issued (no s_wr_req).
  - CLEAR -> DONE when the write to address 2^ADDR_W-1 is issued.
  - DONE asserts clr_done for exactly 1 cycle, then goes to IDLE.
  - clr_busy = 1 in CLEAR only.
  - clr_start in CLEAR or DONE is ignored.
  - Sample writes to addresses at or above the current counter during CLEAR are later overwritten with CLEAR_VAL. This is intended.
- Read port B:
  - Grant is combinational. Video has priority: v_rd_gnt = v_rd_req; h_rd_gnt = h_rd_req & ~v_rd_req.
  - ram_ceb = v_rd_gnt | h_rd_gnt. ram_adb = address of the granted requester; otherwise holds the last value.
  - Requesters hold req/addr stable until gnt is seen.
- Read latency: exactly 1 cycle. v_rd_valid / h_rd_valid are registered copies of v_rd_gnt / h_rd_gnt. rd_data = ram_dout.
  - Back-to-back grants every cycle give a data beat every cycle.
  - Only one valid may be high in any cycle.
- Read/write same address, same cycle: the read returns the old data (RAM write-first behaviour is not relied upon).
- Reset asserted mid-clear:
  - Aborts immediately; clr_done is not pulsed.
  - Pending valids are dropped.
  - RAM contents are undefined for the uncleared range.

Optional Feature:
- Macro: SONAR_RAM_HOST_FAIR_EN.
- Defined:
  - A 3-bit counter increments on each cycle where h_rd_req=1 and h_rd_gnt=0, and clears on any host grant.
  - When the counter is 7 and h_rd_req=1, the host is granted over video for that cycle (v_rd_gnt=0).
  - Host wait is therefore bounded to at most 8 cycles.
- Undefined: strict video priority; the host can starve indefinitely. No counter logic is present.

Test Plan:
- Clear with no traffic: clr_start pulse -> clr_busy high for 4096 cycles, ram_ada counts 0..4095 with ram_din=8'h00, then clr_done high for 1 cycle; readback of address 0x123 returns 0x00.
- Writer preempts clear: s_wr_req held for cycles 10-14 of the clear -> sample writes are issued on those cycles, the clear counter freezes at 10, and clr_done arrives 5 cycles later (4101 cycles total).
- Read priority: v_rd_req and h_rd_req asserted together with addresses 0x010 and 0x020 -> cycle 0 v_rd_gnt, cycle 1 v_rd_valid with rd_data=mem[0x010] and h_rd_gnt, cycle 2 h_rd_valid with rd_data=mem[0x020].
- Write then read: write 0xA5 to 0x7FF, read 0x7FF the next cycle -> h_rd_valid with rd_data=0xA5; a same-cycle read of 0x7FF returns the prior value.
- Reset mid-clear: assert reset at clear cycle 2000 -> clr_busy=0, no clr_done pulse, all valids 0; a new clr_start restarts from address 0.
- With SONAR_RAM_HOST_FAIR_EN: v_rd_req held continuously and h_rd_req raised at cycle 0 -> h_rd_gnt at cycle 7, v_rd_gnt low in that cycle only. Without the macro: h_rd_gnt never asserts.

Source files
------------

// File: rtl/sonar_ram_arbiter.sv
`timescale 1ns/1ps
// sonar_ram_arbiter
//
// Sequencer and arbiter for the simple-dual-port echo buffer RAM
// (write port A, read port B, one cycle of read latency).
//
// Port A is shared by the sonar sample writer and a bulk-clear engine.
// The sample writer always wins. The clear engine sweeps the whole address
// range with CLEAR_VAL, and it only advances on the cycles it actually owns
// the port.
//
// Port B is shared by the video line fetcher and the host readback path.
// Video has priority. Both grants are combinational. The *_rd_valid flags
// are the grants delayed by one cycle, so they line up with ram_dout.
//
// Handshake: a requester raises *_req with a stable address. It keeps both
// stable until it sees its *_gnt high in the same cycle. One cycle later
// the matching *_rd_valid qualifies rd_data. A sample write needs no wait,
// because s_wr_ack is s_wr_req itself.
//
// Optional feature, macro SONAR_RAM_HOST_FAIR_EN:
//   A 3-bit starvation counter tracks how long the host has waited. On the
//   8th waiting cycle the host is granted ahead of video. When the macro is
//   undefined, video priority is strict and no counter exists.
//
// Ports:
//   clk, reset                   system clock, async active-high reset
//   s_wr_req/addr/data, s_wr_ack sample writer
//   clr_start, clr_busy, clr_done bulk-clear control and status
//   v_rd_req/addr, v_rd_gnt, v_rd_valid   video read
//   h_rd_req/addr, h_rd_gnt, h_rd_valid   host read
//   rd_data                      shared read data
//   ram_*                        RAM control pins; ram_dout comes from the RAM
//
// Debug: the clear FSM state is held in 'clr_state' (type clr_state_t).

module sonar_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_wr_req,
  input  logic [ADDR_W-1:0] s_wr_addr,
  input  logic [DATA_W-1:0] s_wr_data,
  output logic              s_wr_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              v_rd_req,
  input  logic [ADDR_W-1:0] v_rd_addr,
  output logic              v_rd_gnt,
  output logic              v_rd_valid,
  input  logic              h_rd_req,
  input  logic [ADDR_W-1:0] h_rd_addr,
  output logic              h_rd_gnt,
  output logic              h_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_cea,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_ceb,
  output logic [ADDR_W-1:0] ram_adb,
  output logic              ram_oce,
  output logic              ram_reseta,
  output logic              ram_resetb,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  clr_state_t        clr_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clear_wr;   // the clear engine owns port A this cycle

  // ---------------------------------------------------------------------------
  // Write port A
  // ---------------------------------------------------------------------------
  assign clear_wr = (clr_state == ST_CLEAR) && !s_wr_req;
  assign s_wr_ack = s_wr_req;

  always_comb begin
    ram_cea = 1'b0;
    ram_ada = clr_cnt;
    ram_din = CLEAR_VAL;
    if (s_wr_req) begin
      ram_cea = 1'b1;
      ram_ada = s_wr_addr;
      ram_din = s_wr_data;
    end else if (clr_state == ST_CLEAR) begin
      ram_cea = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear FSM. clr_busy and clr_done are registered together with the state.
  // A sample write during CLEAR freezes the counter. If that sample write
  // targets an address at or above the counter, the sweep later overwrites
  // it. This is intended.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_state <= ST_IDLE;
      clr_cnt   <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      case (clr_state)
        ST_IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            clr_state <= ST_CLEAR;
            clr_cnt   <= '0;
            clr_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clear_wr) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
              clr_state <= ST_DONE;
              clr_busy  <= 1'b0;
              clr_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          clr_done  <= 1'b0;
          clr_state <= ST_IDLE;
        end
        default: begin
          clr_state <= ST_IDLE;
          clr_busy  <= 1'b0;
          clr_done  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read port B arbitration
  // ---------------------------------------------------------------------------
  logic host_boost;   // host wins over video this cycle

`ifdef SONAR_RAM_HOST_FAIR_EN
  logic [2:0] starve_cnt;

  assign host_boost = h_rd_req && (starve_cnt == 3'd7);

  // The counter counts the host's waiting cycles. Any host grant clears it.
  // When it reaches 7 the host is granted, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 3'd0;
    end else if (h_rd_gnt) begin
      starve_cnt <= 3'd0;
    end else if (h_rd_req) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign host_boost = 1'b0;
`endif

  assign v_rd_gnt = v_rd_req && !host_boost;
  assign h_rd_gnt = h_rd_req && (!v_rd_req || host_boost);
  assign ram_ceb  = v_rd_gnt || h_rd_gnt;

  // The read address is combinational while a grant is active. Otherwise
  // it holds the last granted address, so ram_adb does not toggle while
  // the port is idle.
  logic [ADDR_W-1:0] adb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adb_q <= '0;
    end else if (ram_ceb) begin
      adb_q <= ram_adb;
    end
  end

  always_comb begin
    ram_adb = adb_q;
    if (v_rd_gnt) begin
      ram_adb = v_rd_addr;
    end else if (h_rd_gnt) begin
      ram_adb = h_rd_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: one cycle of latency. At most one grant is high, so at most
  // one valid is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_rd_valid <= 1'b0;
      h_rd_valid <= 1'b0;
    end else begin
      v_rd_valid <= v_rd_gnt;
      h_rd_valid <= h_rd_gnt;
    end
  end

  assign rd_data = ram_dout;

  // ---------------------------------------------------------------------------
  // Static RAM controls
  // ---------------------------------------------------------------------------
  assign ram_oce    = 1'b1;
  assign ram_reseta = reset;
  assign ram_resetb = reset;

endmodule
